rf_portb_arbiter: RTL and testbench

Shares port B of the 32×32 dual-port register file between the operand-fetch second-operand read and the writeback write. Writeback writes are accepted into a small in-order write buffer and drained into the RAM on cycles the read path does not need the port. Buffered data is forwarded to matching reads. Sits between the OF stage, the WB stage and the register-file RAM port B; port A (op1 read) is untouched.

---
 rtl/rf_portb_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_portb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_portb_arbiter.sv
// rf_portb_arbiter: shares RF port B between the OF op2 read and WB writes.
// WB writes queue in an in-order buffer and drain when the read side allows.
// Build option: define RF_PORTB_FWD_EN to forward buffered data to reads;
// when undefined, reads that hit a buffered write stall until it drains.
// Ports:
//   clk, rst (async, active-high)
//   of_req/of_addr -> of_gnt (comb), of_rvalid/of_rdata (one cycle later)
//   wb_req/wb_addr/wb_data -> wb_ack (comb, accepted into buffer)
//   rf_addr/rf_we/rf_din -> RAM port B, rf_dout <- RAM (1-cycle latency)
module rf_portb_arbiter #(
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        of_req,
  input  logic [4:0]  of_addr,
  output logic        of_gnt,
  output logic        of_rvalid,
  output logic [31:0] of_rdata,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ack,
  output logic [4:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] rf_din,
  input  logic [31:0] rf_dout
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    baddr [WBUF_DEPTH];
  logic [31:0]   bdata [WBUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic empty;
  logic full;
  logic drain;
  logic push;
  logic stall_hazard;
  logic match_any;
`ifdef RF_PORTB_FWD_EN
  logic [31:0] match_data;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  assign empty = (count == '0);
  assign full  = (count == CW'(WBUF_DEPTH));

  // Scan oldest to youngest so the last hit is the youngest entry.
  // A grant never coincides with a drain, so the head needs no exclusion.
  always_comb begin
    match_any = 1'b0;
`ifdef RF_PORTB_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (CW'(i) < count &&
          baddr[head + PW'(i)] == of_addr) begin
        match_any = 1'b1;
`ifdef RF_PORTB_FWD_EN
        match_data = bdata[head + PW'(i)];
`endif
      end
    end
  end

`ifdef RF_PORTB_FWD_EN
  assign stall_hazard = 1'b0;
`else
  assign stall_hazard = of_req && match_any;
`endif

  assign drain = !empty &&
                 (!of_req || full ||
                  starve_cnt == SW'(STARVE_LIMIT) ||
                  stall_hazard);

  assign of_gnt = of_req && !drain;
  // Full plus drain frees a slot in the same cycle.
  assign wb_ack = wb_req && (!full || drain);
  assign push   = wb_ack;

  assign rf_we   = drain;
  assign rf_addr = drain ? baddr[head] : of_addr;
  assign rf_din  = drain ? bdata[head] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      baddr[tail] <= wb_addr;
      bdata[tail] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      of_rvalid  <= 1'b0;
    end else begin
      of_rvalid <= of_gnt;
      if (push)
        tail <= tail + 1'b1;
      if (drain)
        head <= head + 1'b1;
      unique case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (empty || drain)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef RF_PORTB_FWD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit <= of_gnt && match_any;
      if (of_gnt && match_any)
        fwd_data <= match_data;
    end
  end

  assign of_rdata = fwd_hit ? fwd_data : rf_dout;
`else
  assign of_rdata = rf_dout;
`endif

endmodule

// File: tb/tb_rf_portb_arbiter.sv
// tb_rf_portb_arbiter: vector table plus scoreboard for rf_portb_arbiter.
// Includes a write-first port-B RAM model driven by the DUT.
module tb_rf_portb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        oq;
    logic [4:0]  oa;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        g;
    logic        k;
    logic        w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        of_req = 1'b0;
  logic [4:0]  of_addr = '0;
  logic        of_gnt;
  logic        of_rvalid;
  logic [31:0] of_rdata;
  logic        wb_req = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ack;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_din;
  logic [31:0] rf_dout = '0;

  logic [31:0] mem [32] = '{default: 32'h0};
  logic [31:0] arch [32];

  int total = 0;
  int bad = 0;
  int mstarve = 0;
  wr_t wq[$];
  logic [31:0] rdq[$];
  vec_t tbl[$];
  logic s_gnt, s_ack, s_we;

  always #5 clk = ~clk;

  rf_portb_arbiter #(
    .WBUF_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .of_req(of_req), .of_addr(of_addr),
    .of_gnt(of_gnt), .of_rvalid(of_rvalid),
    .of_rdata(of_rdata),
    .wb_req(wb_req), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_ack(wb_ack),
    .rf_addr(rf_addr), .rf_we(rf_we),
    .rf_din(rf_din), .rf_dout(rf_dout)
  );

  // Write-first synchronous RAM, port B.
  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_addr] <= rf_din;
      rf_dout <= rf_din;
    end else begin
      rf_dout <= mem[rf_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(
      input logic oq, input logic [4:0] oa,
      input logic wr, input logic [4:0] wa,
      input logic [31:0] wd,
      input logic g, input logic k, input logic w);
    vec_t v;
    v.oq = oq; v.oa = oa; v.wr = wr;
    v.wa = wa; v.wd = wd;
    v.g = g; v.k = k; v.w = w;
    tbl.push_back(v);
  endfunction

  // One clock: drive at negedge, check before the next posedge.
  task automatic cycle(input logic oq, input logic [4:0] oa,
                       input logic wr, input logic [4:0] wa,
                       input logic [31:0] wd);
    int cnt;
    logic hz, edr, eg, ea;
    wr_t e;
    @(negedge clk);
    of_req = oq; of_addr = oa;
    wb_req = wr; wb_addr = wa; wb_data = wd;
    #1;
    chk("rvalid", of_rvalid, rdq.size() != 0);
    if (rdq.size() != 0)
      chk("rdata", of_rdata, rdq.pop_front());
    cnt = wq.size();
    hz = 1'b0;
`ifndef RF_PORTB_FWD_EN
    foreach (wq[i])
      if (oq && wq[i].a == oa) hz = 1'b1;
`endif
    edr = cnt != 0 &&
          (!oq || cnt == DEPTH || mstarve == LIMIT || hz);
    eg = oq && !edr;
    ea = wr && (cnt < DEPTH || edr);
    s_gnt = of_gnt; s_ack = wb_ack; s_we = rf_we;
    chk("rf_we", rf_we, edr);
    chk("of_gnt", of_gnt, eg);
    chk("wb_ack", wb_ack, ea);
    if (edr) begin
      e = wq.pop_front();
      chk("wr_addr", rf_addr, e.a);
      chk("wr_data", rf_din, e.d);
    end else begin
      chk("rd_addr", rf_addr, oa);
    end
    if (cnt == 0 || edr) mstarve = 0;
    else if (mstarve < LIMIT) mstarve++;
    if (eg) rdq.push_back(arch[oa]);
    if (ea) begin
      e.a = wa; e.d = wd;
      wq.push_back(e);
      arch[wa] = wd;
    end
  endtask

  initial begin
    int stalls;
    logic got;
    logic r_oq, r_wr;
    logic [4:0] r_oa, r_wa;
    logic [31:0] r_wd;
    foreach (arch[i]) arch[i] = '0;

    // Idle pattern, then a lone write, then starvation and full.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 10, 32'h10, 1, 1, 0);
    add(1, 1, 1, 11, 32'h11, 1, 1, 0);
    add(1, 1, 1, 12, 32'h12, 1, 1, 0);
    add(1, 1, 1, 13, 32'h13, 1, 1, 0);
    add(1, 1, 1, 14, 32'h14, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      add(1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 1);
    end
    add(1, 1, 0, 0, 0, 1, 0, 0);

    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_rvalid", of_rvalid, 0);
    chk("rst_ack", wb_ack, 0);
    chk("rst_gnt", of_gnt, 0);
    chk("rst_rdata", of_rdata, rf_dout);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].oq, tbl[i].oa, tbl[i].wr,
            tbl[i].wa, tbl[i].wd);
      chk($sformatf("vec%0d_gnt", i), s_gnt, tbl[i].g);
      chk($sformatf("vec%0d_ack", i), s_ack, tbl[i].k);
      chk($sformatf("vec%0d_we", i), s_we, tbl[i].w);
    end

    // r7=1 then r7=2 buffered, then read r7.
    cycle(1, 1, 1, 7, 32'd1);
    cycle(1, 1, 1, 7, 32'd2);
    stalls = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle(1, 7, 0, 0, 0);
      if (s_gnt) got = 1'b1;
      else stalls++;
    end
    chk("r7_gnt_seen", got, 1);
`ifdef RF_PORTB_FWD_EN
    chk("r7_stalls", stalls, 0);
    chk("r7_ram_untouched", mem[7], 0);
`else
    chk("r7_stalls", stalls, 2);
`endif
    cycle(0, 0, 0, 0, 0);
    chk("r7_rdata", of_rdata, 32'd2);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Reset with three buffered writes and a read in flight.
    cycle(1, 1, 1, 20, 32'hA0);
    cycle(1, 1, 1, 21, 32'hA1);
    cycle(1, 1, 1, 22, 32'hA2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    of_req = 1'b0;
    wb_req = 1'b0;
    #1;
    chk("mid_rst_rvalid", of_rvalid, 0);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_gnt", of_gnt, 0);
    wq.delete();
    rdq.delete();
    mstarve = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("in_rst_we", rf_we, 0);
    end
    rst = 1'b0;
    foreach (arch[i]) arch[i] = mem[i];
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Mixed traffic on a few registers.
    for (int k = 0; k < 400; k++) begin
      r_oq = 1'($urandom_range(0, 3) != 0);
      r_oa = 5'($urandom_range(0, 7));
      r_wr = 1'($urandom_range(0, 1));
      r_wa = 5'($urandom_range(0, 7));
      r_wd = $urandom();
      cycle(r_oq, r_oa, r_wr, r_wa, r_wd);
    end
    repeat (8) cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++)
      chk($sformatf("ram_r%0d", r), mem[r], arch[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
